// File: rtl/mips_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_hazard_pkg
// Brief  : Shared forwarding encodings, HI/LO latencies and the shadow slot.
// Rev    : 1.0
// ============================================================================
package mips_hazard_pkg;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_WB    = 2'd2;

    localparam logic [5:0] MULT_LAT  = 6'd5;
    localparam logic [5:0] DIV_LAT   = 6'd33;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       wr_en;
        logic       is_load;
        logic       is_store;
    } slot_t;

    // Youngest producer wins; a load in MEM has no ALU result to hand over yet.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input slot_t      mem,
                                           input slot_t      wb);
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != 5'd0) begin
            if (mem.valid && mem.wr_en && !mem.is_load && (mem.rd == src))
                sel = FWD_EXMEM;
            else if (wb.valid && wb.wr_en && (wb.rd == src))
                sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_ctrl_if
// Brief  : ID-stage decode inputs and hazard/forwarding control outputs.
// Rev    : 1.0
// ============================================================================
interface fwd_hazard_ctrl_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] id_rd;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wr_en;
    logic       id_is_load;
    logic       id_is_store;
    logic       id_is_mult;
    logic       id_is_div;
    logic       id_rd_hilo;
    logic       hold;
    logic       stall;
    logic [1:0] ex_fwd_rs;
    logic [1:0] ex_fwd_rt;
    logic       mem_rt_fwd;
    logic       muldiv_busy;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_wr_en,
               id_is_load, id_is_store, id_is_mult, id_is_div, id_rd_hilo, hold,
        input  stall, ex_fwd_rs, ex_fwd_rt, mem_rt_fwd, muldiv_busy
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_use_rs, id_use_rt, id_wr_en,
               id_is_load, id_is_store, id_is_mult, id_is_div, id_rd_hilo, hold,
        output stall, ex_fwd_rs, ex_fwd_rt, mem_rt_fwd, muldiv_busy
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_busy_ctr.sv
`default_nettype none
// ============================================================================
// Module : muldiv_busy_ctr
// Brief  : HI/LO occupancy countdown; keeps running while the pipeline holds.
// Rev    : 1.0
// ============================================================================
module muldiv_busy_ctr
    import mips_hazard_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_start_mult,
    input  wire logic i_start_div,
    output logic      o_busy
);

    logic [5:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_cnt <= 6'd0;
        else if (i_start_div)
            r_cnt <= DIV_LAT;
        else if (i_start_mult)
            r_cnt <= MULT_LAT;
        else if (r_cnt != 6'd0)
            r_cnt <= r_cnt - 6'd1;
    end

    assign o_busy = (r_cnt != 6'd0);

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : fwd_hazard_ctrl
// Brief  : Shadow EX/MEM/WB slots driving load-use, HI/LO stalls and forwarding.
// Rev    : 1.0
// ============================================================================
module fwd_hazard_ctrl
    import mips_hazard_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst_n,
    fwd_hazard_ctrl_if.slave  bus
);

    slot_t r_ex;
    slot_t r_mem;
    slot_t r_wb;
    slot_t w_id_slot;
    logic  w_load_use;
    logic  w_hilo_stall;
    logic  w_stall;
    logic  w_advance;
    logic  w_busy;
    logic  w_unused;

    always_comb begin
        w_id_slot          = '0;
        w_id_slot.valid    = 1'b1;
        w_id_slot.rs       = bus.id_rs;
        w_id_slot.rt       = bus.id_rt;
        w_id_slot.rd       = bus.id_rd;
        w_id_slot.wr_en    = bus.id_wr_en;
        w_id_slot.is_load  = bus.id_is_load;
        w_id_slot.is_store = bus.id_is_store;
    end

    assign w_load_use = bus.id_valid && r_ex.valid && r_ex.is_load && r_ex.wr_en
                      && (r_ex.rd != 5'd0)
                      && ((bus.id_use_rs && (bus.id_rs == r_ex.rd))
                       || (bus.id_use_rt && (bus.id_rt == r_ex.rd)));

    assign w_hilo_stall = bus.id_valid && w_busy
                        && (bus.id_rd_hilo || bus.id_is_mult || bus.id_is_div);

    assign w_stall   = w_load_use || w_hilo_stall;
    assign w_advance = bus.id_valid && !w_stall && !bus.hold;

    // Bubbles are fully zeroed so their register fields never match anything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!bus.hold) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            r_ex  <= (w_stall || !bus.id_valid) ? slot_t'('0) : w_id_slot;
        end
    end

    muldiv_busy_ctr u_busy_ctr (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start_mult (w_advance && bus.id_is_mult),
        .i_start_div  (w_advance && bus.id_is_div),
        .o_busy       (w_busy)
    );

    assign bus.stall       = w_stall;
    assign bus.muldiv_busy = w_busy;
    assign bus.ex_fwd_rs   = fwd_sel(r_ex.rs, r_mem, r_wb);
    assign bus.ex_fwd_rt   = fwd_sel(r_ex.rt, r_mem, r_wb);
    assign bus.mem_rt_fwd  = r_mem.valid && r_mem.is_store && r_wb.valid && r_wb.wr_en
                           && (r_wb.rd != 5'd0) && (r_wb.rd == r_mem.rt);

    assign w_unused = ^{r_wb.rs, r_wb.rt, r_wb.is_load, r_wb.is_store, r_mem.rs};

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_fwd_hazard_ctrl
// Brief  : Directed vectors with hand-computed selects, stalls and busy counts.
// Rev    : 1.0
// ============================================================================
module tb_fwd_hazard_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   n_cyc;

    fwd_hazard_ctrl_if bus ();

    fwd_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic urs, input logic urt, input logic wr,
                         input logic ld, input logic st, input logic mul,
                         input logic dv, input logic hilo);
        bus.id_valid    = 1'b1;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rd       = rd;
        bus.id_use_rs   = urs;
        bus.id_use_rt   = urt;
        bus.id_wr_en    = wr;
        bus.id_is_load  = ld;
        bus.id_is_store = st;
        bus.id_is_mult  = mul;
        bus.id_is_div   = dv;
        bus.id_rd_hilo  = hilo;
    endtask

    task automatic nop();
        instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.id_valid = 1'b0;
    endtask

    task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        instr(rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic flush();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        bus.hold = 1'b0;
        nop();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_stall",   bus.stall,       0);
        check("rst_fwd_rs",  bus.ex_fwd_rs,   0);
        check("rst_fwd_rt",  bus.ex_fwd_rt,   0);
        check("rst_mem_rt",  bus.mem_rt_fwd,  0);
        check("rst_busy",    bus.muldiv_busy, 0);

        // add $3 ; sub $6,$3,$4 -> EX/MEM forward on rs
        alu(5'd1, 5'd2, 5'd3); tick();
        alu(5'd3, 5'd4, 5'd6); tick();
        nop(); #1;
        check("exmem_fwd_rs", bus.ex_fwd_rs, 1);
        check("exmem_fwd_rt", bus.ex_fwd_rt, 0);
        flush();

        // add $3 ; filler ; consumer of $3 on both operands -> WB forward
        alu(5'd1, 5'd2, 5'd3);  tick();
        alu(5'd8, 5'd9, 5'd10); tick();
        alu(5'd3, 5'd3, 5'd11); tick();
        nop(); #1;
        check("wb_fwd_rs", bus.ex_fwd_rs, 2);
        check("wb_fwd_rt", bus.ex_fwd_rt, 2);
        flush();

        // lw $5 ; add reading $5 as rt -> one stall, then WB forward
        instr(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        alu(5'd2, 5'd5, 5'd6); #1;
        check("lu_stall_on",  bus.stall, 1);
        tick();
        check("lu_stall_off", bus.stall, 0);
        check("lu_bubble_rt", bus.ex_fwd_rt, 0);
        tick();
        nop(); #1;
        check("lu_fwd_rt", bus.ex_fwd_rt, 2);
        check("lu_fwd_rs", bus.ex_fwd_rs, 0);
        flush();

        // add $7 ; sw rt=$7 -> EX forward, then store-data forward in MEM
        alu(5'd1, 5'd2, 5'd7); tick();
        instr(5'd1, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        nop(); #1;
        check("sw_ex_fwd_rt", bus.ex_fwd_rt, 1);
        check("sw_ex_memrt",  bus.mem_rt_fwd, 0);
        tick();
        check("sw_mem_rt_fwd", bus.mem_rt_fwd, 1);
        flush();

        // same with $0 -> nothing forwards
        alu(5'd1, 5'd2, 5'd0); tick();
        instr(5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        nop(); #1;
        check("r0_fwd_rt", bus.ex_fwd_rt, 0);
        check("r0_fwd_rs", bus.ex_fwd_rs, 0);
        tick();
        check("r0_mem_rt", bus.mem_rt_fwd, 0);
        flush();

        // div ; mflo -> 33 stall cycles
        instr(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        instr(5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
        check("div_busy", bus.muldiv_busy, 1);
        n_cyc = 0;
        while (bus.stall && n_cyc < 40) begin
            n_cyc++;
            tick();
        end
        check("div_stall_cycles", n_cyc, 33);
        check("div_busy_fall",    bus.muldiv_busy, 0);
        tick();
        flush();

        // mult ; mflo -> 5 stall cycles
        instr(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        instr(5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
        n_cyc = 0;
        while (bus.stall && n_cyc < 40) begin
            n_cyc++;
            tick();
        end
        check("mult_stall_cycles", n_cyc, 5);
        tick();
        flush();

        // hold for 3 cycles inside a load-use pair
        instr(5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        alu(5'd2, 5'd5, 5'd6); #1;
        check("hold_lu_stall", bus.stall, 1);
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("hold_stall_%0d", i), bus.stall, 1);
        end
        bus.hold = 1'b0; #1;
        check("hold_release_stall", bus.stall, 1);
        tick();
        check("hold_single_bubble", bus.stall, 0);
        tick();
        nop(); #1;
        check("hold_fwd_rt", bus.ex_fwd_rt, 2);
        flush();

        // reset mid-divide with counter at 20, hold asserted alongside
        instr(5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        nop();
        repeat (13) tick();
        check("mid_div_busy", bus.muldiv_busy, 1);
        rst_n    = 1'b0;
        bus.hold = 1'b1;
        instr(5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check("abort_busy",   bus.muldiv_busy, 0);
        check("abort_stall",  bus.stall,       0);
        check("abort_fwd_rs", bus.ex_fwd_rs,   0);
        check("abort_fwd_rt", bus.ex_fwd_rt,   0);
        check("abort_mem_rt", bus.mem_rt_fwd,  0);
        rst_n    = 1'b1;
        bus.hold = 1'b0;
        flush();

        // MEM and WB both write $4 -> youngest (MEM) wins
        alu(5'd1, 5'd2, 5'd4); tick();
        alu(5'd1, 5'd2, 5'd4); tick();
        alu(5'd4, 5'd5, 5'd9); tick();
        nop(); #1;
        check("both_fwd_rs", bus.ex_fwd_rs, 1);
        check("both_fwd_rt", bus.ex_fwd_rt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 The ports SHALL be: clk  in  1  sole clock, all state updates on its rising edge.
REQ-002 The ports SHALL include: rst_n  in  1  synchronous, active-low reset.
REQ-003 The ports SHALL include: id_valid  in  1  ID stage holds a real instruction.
REQ-004 The ports SHALL include: id_rs, id_rt, id_rd  in  5 each  ID source and destination register numbers.
REQ-005 The ports SHALL include: id_use_rs, id_use_rt, id_wr_en  in  1 each  ID reads rs, reads rt, writes rd.
REQ-006 The ports SHALL include: id_is_load, id_is_store, id_is_mult, id_is_div, id_rd_hilo  in  1 each  ID instruction class.
REQ-007 The ports SHALL include: hold  in  1  external memory wait; freezes all pipeline slots.
REQ-008 The ports SHALL include: stall  out  1  hold PC and IF/ID, inject bubble into EX.
REQ-009 The ports SHALL include: ex_fwd_rs, ex_fwd_rt  out  2 each  EX operand select (0 = ID/EX register, 1 = EX/MEM ALU result, 2 = WB-mux result).
REQ-010 The ports SHALL include: mem_rt_fwd  out  1  EX/MEM rt store-data select (0 = EX/MEM rt, 1 = WB-mux result).
REQ-011 The ports SHALL include: muldiv_busy  out  1  HI/LO unit occupied.

Function
REQ-012 The block SHALL track three shadow slots, EX, MEM and WB, each holding {valid, rs, rt, rd, wr_en, is_load, is_store}.
REQ-013 When hold=0, each rising edge SHALL move WB<=MEM and MEM<=EX, and SHALL load EX from the ID inputs; if stall=1 or id_valid=0, EX SHALL be loaded with valid=0 instead.
REQ-014 When hold=1, all slots SHALL keep their values, and stall SHALL still be computed.
REQ-015 Load-use: stall SHALL be 1 combinationally when id_valid, EX.valid, EX.is_load, EX.wr_en and EX.rd!=0 all hold, and EX.rd matches id_rs with id_use_rs=1 or id_rt with id_use_rt=1.
REQ-016 The load-use stall SHALL last exactly one cycle; the consumer then forwards from WB (select 2).
REQ-017 ex_fwd_rs SHALL be 1 when EX.rs matches the rd of a valid, non-load MEM slot with wr_en=1; otherwise it SHALL be 2 when EX.rs matches a valid WB slot with wr_en=1; otherwise it SHALL be 0; ex_fwd_rt SHALL follow the same rule on EX.rt.
REQ-018 When MEM and WB both match, MEM SHALL win (youngest producer).
REQ-019 Register 0 SHALL never cause a forward or a stall.
REQ-020 mem_rt_fwd SHALL be 1 when MEM.valid, MEM.is_store, WB.valid, WB.wr_en and WB.rd!=0 all hold and WB.rd==MEM.rt.
REQ-021 Busy counter (6 bits): it SHALL load MULT_LAT=5 when an id_is_mult instruction advances into EX, or DIV_LAT=33 for id_is_div; otherwise it SHALL decrement when nonzero and saturate at 0.
REQ-022 The busy counter SHALL also count while hold=1.
REQ-023 muldiv_busy SHALL equal (counter != 0).
REQ-024 stall SHALL also be 1 when id_valid and muldiv_busy are both 1 and (id_rd_hilo or id_is_mult or id_is_div) is 1.
REQ-025 The final stall SHALL be load-use OR HI/LO stall.
REQ-026 All outputs SHALL be combinational from the slots, the counter and the ID inputs, with no added latency.
REQ-027 For simultaneous conditions: a load-use stall and a HI/LO stall in the same cycle SHALL produce a single stall; a new mult/div is never issued while busy.

Reset
REQ-028 While rst_n=0 at a rising edge, all slot valid bits, fields and the busy counter SHALL be cleared.
REQ-029 Consequently, after reset stall=0, ex_fwd_rs=ex_fwd_rt=0, mem_rt_fwd=0 and muldiv_busy=0.
REQ-030 Reset mid-divide SHALL abort the count immediately, and reset SHALL take priority over hold.

Structure
REQ-031 The shared package mips_hazard_pkg SHALL hold the forwarding-select encodings (FWD_REG=0, FWD_EXMEM=1, FWD_WB=2), MULT_LAT, DIV_LAT and the slot struct typedef.
REQ-032 The busy counter SHALL be a sub-module named muldiv_busy_ctr; the slot pipeline and compare logic SHALL stay in fwd_hazard_ctrl.

Verification
REQ-033 The bench SHALL cover: add $3 then, next cycle, sub uses $3 as rs -> ex_fwd_rs=1 in the sub's EX cycle; one instruction later -> ex_fwd_rs=2.
REQ-034 The bench SHALL cover: lw $5 followed by add reading $5 as rt -> stall=1 for exactly one cycle, then ex_fwd_rt=2, with no EX/MEM forward.
REQ-035 The bench SHALL cover: add $7 then sw with rt=$7 two slots later -> mem_rt_fwd=1 in the sw's MEM cycle; the same sequence with $0 -> all selects 0.
REQ-036 The bench SHALL cover: div then immediate mflo -> stall held 33 cycles, muldiv_busy falls on cycle 33, mflo proceeds on the next cycle; mult gives 5 cycles.
REQ-037 The bench SHALL cover: hold=1 for 3 cycles during a load-use pair -> slots frozen, stall stays 1, and a single bubble results after release.
REQ-038 The bench SHALL cover: rst_n=0 mid-div (counter=20) -> next edge muldiv_busy=0, all outputs 0; both MEM and WB writing $4 -> ex_fwd_rs=1.
